// File: rtl/sync_fifo_cfg.sv
// Synchronous FIFO with arbitrary depth, occupancy count, runtime threshold,
// sticky overflow/underflow flags and optional first-word-fall-through read.
module sync_fifo_cfg #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 48,
    parameter int FWFT       = 0,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [CW-1:0]         thresh,
    input  logic                  clr_flags,
    output logic [CW-1:0]         count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_threshold,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_ok, wr_ok;

    assign count          = count_q;
    assign fifo_full      = (count_q == FULL_LVL);
    assign fifo_empty     = (count_q == '0);
    assign fifo_threshold = (count_q >= thresh);
    assign fifo_overflow  = overflow_q;
    assign fifo_underflow = underflow_q;

    always_comb begin
        rd_ok       = rd & ~fifo_empty;
        // A full FIFO still takes a write when a read frees a slot this cycle.
        wr_ok       = wr & (~fifo_full | rd_ok);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + AW'(1);
        end

        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end

        // Set events are applied after the clear so they win a same-cycle tie.
        if (clr_flags) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr && !wr_ok) begin
            overflow_d = 1'b1;
        end
        if (rd && !rd_ok) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; only the write port is gated off during reset.
    always_ff @(posedge clk) begin
        if (resetn && wr_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = fifo_empty ? '0 : mem[rd_ptr_q];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[rd_ptr_q];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Drives three FIFO configurations with one shared stimulus stream and checks
// each against a queue-based reference model every cycle.
module tb_sync_fifo_cfg;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr;
    logic          rd;
    logic          clr_flags;
    logic [DW-1:0] data_in;
    logic [7:0]    thresh;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int D  = (gi == 0) ? 4 : (gi == 1) ? 3 : 5;
        localparam int F  = (gi == 2) ? 1 : 0;
        localparam int CW = $clog2(D + 1);

        logic [DW-1:0] data_out;
        logic [CW-1:0] count;
        logic          full, empty, thr, ovf, unf;

        sync_fifo_cfg #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(F)) u_dut (
            .clk           (clk),
            .resetn        (resetn),
            .wr            (wr),
            .data_in       (data_in),
            .rd            (rd),
            .data_out      (data_out),
            .thresh        (thresh[CW-1:0]),
            .clr_flags     (clr_flags),
            .count         (count),
            .fifo_full     (full),
            .fifo_empty    (empty),
            .fifo_threshold(thr),
            .fifo_overflow (ovf),
            .fifo_underflow(unf)
        );

        logic [DW-1:0] q[$];
        logic [DW-1:0] m_dout = '0;
        bit            m_ovf  = 1'b0;
        bit            m_unf  = 1'b0;

        always @(posedge clk) begin
            bit            rok, wok;
            logic [DW-1:0] popped;
            logic [DW-1:0] exp_dout;
            int            n;

            if (!resetn) begin
                q.delete();
                m_dout = '0;
                m_ovf  = 1'b0;
                m_unf  = 1'b0;
            end else begin
                rok = rd && (q.size() > 0);
                wok = wr && ((q.size() < D) || rok);
                if (rok) begin
                    popped = q.pop_front();
                    if (F == 0) m_dout = popped;
                end
                if (wok) q.push_back(data_in);
                if (wr && !wok) m_ovf = 1'b1;
                else if (clr_flags) m_ovf = 1'b0;
                if (rd && !rok) m_unf = 1'b1;
                else if (clr_flags) m_unf = 1'b0;
            end

            #1;
            n = q.size();
            if (F != 0) exp_dout = (n > 0) ? q[0] : '0;
            else        exp_dout = m_dout;
            check($sformatf("cfg%0d count", gi), 32'(count), 32'(n));
            check($sformatf("cfg%0d full", gi), 32'(full), 32'(n == D));
            check($sformatf("cfg%0d empty", gi), 32'(empty), 32'(n == 0));
            check($sformatf("cfg%0d threshold", gi), 32'(thr), 32'(n >= int'(thresh[CW-1:0])));
            check($sformatf("cfg%0d overflow", gi), 32'(ovf), 32'(m_ovf));
            check($sformatf("cfg%0d underflow", gi), 32'(unf), 32'(m_unf));
            check($sformatf("cfg%0d data_out", gi), 32'(data_out), 32'(exp_dout));
        end
    end

    // Apply one cycle of stimulus; inputs change 2 time units after the edge.
    task automatic drive(input logic rn, input logic w, input logic r,
                         input logic [DW-1:0] d, input logic c);
        resetn    = rn;
        wr        = w;
        rd        = r;
        data_in   = d;
        clr_flags = c;
        n_txn++;
        $display("txn %0d: resetn=%0b wr=%0b rd=%0b din=%02h clr=%0b thresh=%0d",
                 n_txn, rn, w, r, d, c, thresh);
        @(posedge clk);
        #2;
    endtask

    initial begin
        thresh = 8'd3;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Fill and drain.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Wrap-around.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 8'hB0 + 8'(i), 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'hB3, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'hB4, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Overflow, clear racing a new overflow, then a plain clear.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 8'hD0 + 8'(i), 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'hFE, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous read/write when full and when empty.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 8'hE0 + 8'(i), 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hE4, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hF0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Fall-through behaviour and live threshold changes.
        thresh = 8'd0;
        drive(1'b1, 1'b1, 1'b0, 8'hC0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        thresh = 8'd1;
        drive(1'b1, 1'b1, 1'b0, 8'hC1, 1'b0);
        thresh = 8'd2;
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset mid-stream with a write pending.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);

        // Randomized traffic, alternating write-heavy and read-heavy bursts.
        for (int i = 0; i < 240; i++) begin
            int wp;
            wp = ((i / 20) % 2 == 0) ? 75 : 30;
            if ($urandom_range(0, 15) == 0) thresh = 8'($urandom_range(0, 5));
            drive(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 99) < wp),
                  ($urandom_range(0, 99) < (100 - wp)),
                  8'($urandom),
                  ($urandom_range(0, 9) == 0));
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
